// File: rtl/prog_fetch_mem.sv
// rtl/prog_fetch_mem.sv - program memory with sequential prefetcher and valid/ready instruction stream
// Optional PROG_MEM_PARITY_EN adds a stored even-parity bit per word, checked on fetch.
module prog_fetch_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MEM_SIZE    = 4096,
    parameter int FETCH_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_start,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  fetch_stop,
    output logic                  fetch_active,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_err,
    input  logic                  cfg_write_en,
    input  logic [ADDR_WIDTH-1:0] cfg_write_addr,
    input  logic [DATA_WIDTH-1:0] cfg_write_data
);
`ifdef PROG_MEM_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif
    localparam int MEM_AW = $clog2(MEM_SIZE);
    localparam int PTR_W  = $clog2(FETCH_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic {IDLE, FETCH} state_t;
    state_t state, state_next;

    logic [WORD_W-1:0]     mem [MEM_SIZE] = '{default: '0};
    logic [WORD_W-1:0]     rd_word;
    logic [WORD_W-1:0]     wr_word;
    logic                  rd_par_err;

    logic [DATA_WIDTH-1:0] q_data [FETCH_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [FETCH_DEPTH];
    logic                  q_err  [FETCH_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr, oldest_ptr;
    logic [CNT_W-1:0]      count, remain;

    logic [ADDR_WIDTH-1:0] next_pc, inflight_addr, resume_pc;
    logic                  inflight, inflight_oor;
    logic                  wr_in_range, rd_in_range;
    logic                  issue, flush, push, pop;

`ifdef PROG_MEM_PARITY_EN
    assign wr_word    = {^cfg_write_data, cfg_write_data};
    assign rd_par_err = ^rd_word;
`else
    assign wr_word    = cfg_write_data;
    assign rd_par_err = 1'b0;
`endif

    assign wr_in_range = {1'b0, cfg_write_addr} < MEM_LIMIT;
    assign rd_in_range = {1'b0, next_pc} < MEM_LIMIT;

    assign instr_valid  = count != '0;
    assign instr_data   = instr_valid ? q_data[rd_ptr] : '0;
    assign instr_addr   = instr_valid ? q_addr[rd_ptr] : '0;
    assign instr_err    = instr_valid ? q_err[rd_ptr] : 1'b0;
    assign fetch_active = state == FETCH;

    assign pop   = instr_valid && instr_ready;
    assign flush = fetch_start || (state == FETCH && (fetch_stop || cfg_write_en));
    assign push  = inflight && !flush;
    assign issue = state == FETCH && !cfg_write_en && !fetch_start && !fetch_stop &&
                   (count + CNT_W'(inflight) < CNT_W'(FETCH_DEPTH));

    // After a coherence flush, refetch from the oldest entry the decoder has not taken yet.
    assign remain     = count - CNT_W'(pop);
    assign oldest_ptr = rd_ptr + PTR_W'(pop);
    assign resume_pc  = (remain != '0) ? q_addr[oldest_ptr] :
                        inflight       ? inflight_addr      : next_pc;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fetch_start) state_next = FETCH;
            FETCH:   if (fetch_start) state_next = FETCH;
                     else if (fetch_stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Array is not reset; contents survive reset.
    always_ff @(posedge clock) begin
        if (cfg_write_en && wr_in_range) mem[cfg_write_addr[MEM_AW-1:0]] <= wr_word;
        if (issue && rd_in_range)        rd_word <= mem[next_pc[MEM_AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_oor  <= 1'b0;
            next_pc       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= next_pc;
                inflight_oor  <= !rd_in_range;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= inflight_oor ? '0 : rd_word[DATA_WIDTH-1:0];
                    q_addr[wr_ptr] <= inflight_addr;
                    q_err[wr_ptr]  <= inflight_oor || rd_par_err;
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
            if (fetch_start)
                next_pc <= fetch_pc;
            else if (state == FETCH && cfg_write_en)
                next_pc <= resume_pc;
            else if (issue)
                next_pc <= next_pc + 1'b1;
        end
    end
endmodule

// File: tb/tb_prog_fetch_mem.sv
// tb/tb_prog_fetch_mem.sv - scoreboard bench for prog_fetch_mem
module tb_prog_fetch_mem;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MS = 4094;
    localparam int FD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          fetch_start, fetch_stop, fetch_active;
    logic          instr_valid, instr_ready, instr_err, cfg_write_en;
    logic [AW-1:0] fetch_pc, instr_addr, cfg_write_addr;
    logic [DW-1:0] instr_data, cfg_write_data;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } entry_t;

    entry_t        exp_q[$];
    entry_t        mon_e;
    entry_t        drv_e;
    logic [DW-1:0] model [1<<AW];
    int            checks = 0;
    int            errors = 0;
    int            pops = 0;
    int            pop_limit = -1;
    int            cyc = 0;
    int            elapsed;

    always #5 clock = ~clock;

    prog_fetch_mem #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .FETCH_DEPTH(FD)
    ) dut (
        .clock(clock), .reset(reset),
        .fetch_start(fetch_start), .fetch_pc(fetch_pc), .fetch_stop(fetch_stop),
        .fetch_active(fetch_active),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr), .instr_err(instr_err),
        .cfg_write_en(cfg_write_en), .cfg_write_addr(cfg_write_addr),
        .cfg_write_data(cfg_write_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic entry_t mk(input logic [AW-1:0] a);
        entry_t e;
        e.addr = a;
        e.err  = int'(a) >= MS;
        e.data = e.err ? '0 : model[a];
        return e;
    endfunction

    task automatic expect_from(input logic [AW-1:0] pc, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(pc + AW'(i)));
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_write_en   = 1'b1;
        cfg_write_addr = a;
        cfg_write_data = d;
        @(posedge clock); #1;
        cfg_write_en = 1'b0;
        if (int'(a) < MS) begin
            model[a] = d;
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i].addr == a) begin
                    drv_e      = exp_q[i];
                    drv_e.data = d;
                    exp_q[i]   = drv_e;
                end
        end
    endtask

    task automatic start_fetch(input logic [AW-1:0] pc);
        fetch_pc    = pc;
        fetch_start = 1'b1;
        @(posedge clock); #1;
        fetch_start = 1'b0;
    endtask

    // Waits for the monitor to drop ready at the pop limit, then stops the prefetcher.
    task automatic finish_stream(output int el);
        int c0 = cyc;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #2;
            if (!instr_ready) break;
        end
        check_eq("drain_done", instr_ready, 0);
        instr_ready = 1'b0;
        el         = cyc - c0;
        pop_limit  = -1;
        fetch_stop = 1'b1;
        @(posedge clock); #1;
        fetch_stop = 1'b0;
        check_eq("leftover", exp_q.size(), 0);
        check_eq("stopped", fetch_active, 0);
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (!reset && instr_valid && instr_ready) begin
            check_eq("exp_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("addr", instr_addr, mon_e.addr);
                check_eq("data", instr_data, mon_e.data);
                check_eq("err", instr_err, mon_e.err);
            end
            pops++;
            if (pops == pop_limit) begin
                @(posedge clock); #1;
                instr_ready = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) model[i] = '0;
        reset = 1'b1; fetch_start = 1'b0; fetch_stop = 1'b0; fetch_pc = '0;
        instr_ready = 1'b0; cfg_write_en = 1'b0; cfg_write_addr = '0; cfg_write_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_active", fetch_active, 0);
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_data", instr_data, 0);
        check_eq("rst_addr", instr_addr, 0);
        check_eq("rst_err", instr_err, 0);
        reset = 1'b0;

        for (int i = 0; i < 48; i++)
            cfg_write(AW'(i), (i < 3) ? DW'(32'h11 * (i + 1)) : DW'($urandom));

        // latency and consecutive delivery
        expect_from(0, 3);
        pop_limit = pops + 3;
        instr_ready = 1'b1;
        fetch_pc = '0; fetch_start = 1'b1;
        @(posedge clock); #1;
        fetch_start = 1'b0;
        check_eq("t1_active", fetch_active, 1);
        check_eq("t1_lat0", instr_valid, 0);
        @(posedge clock); #1;
        check_eq("t1_lat1", instr_valid, 0);
        @(posedge clock); #1;
        check_eq("t1_lat2", instr_valid, 1);
        check_eq("t1_head0", instr_addr, 0);
        check_eq("t1_data0", instr_data, 32'h11);
        @(posedge clock); #2;
        check_eq("t1_head1", instr_addr, 1);
        @(posedge clock); #2;
        check_eq("t1_head2", instr_addr, 2);
        finish_stream(elapsed);

        // back-pressure: buffer fills to depth, head holds, then drains at full rate
        expect_from(4, 8);
        pop_limit = pops + 8;
        start_fetch(4);
        repeat (8) begin @(posedge clock); #1; end
        check_eq("stall_valid", instr_valid, 1);
        check_eq("stall_addr", instr_addr, 4);
        check_eq("stall_data", instr_data, model[4]);
        repeat (3) begin @(posedge clock); #1; end
        check_eq("stall_stable", instr_data, model[4]);
        instr_ready = 1'b1;
        finish_stream(elapsed);
        check_eq("stall_rate", elapsed, 8);

        // out-of-range window and address wrap
        cfg_write(AW'(4093), 32'hDEAD_0001);
        cfg_write(AW'(4094), 32'hBAD0_BAD0);
        expect_from(AW'(4093), 4);
        pop_limit = pops + 4;
        instr_ready = 1'b1;
        start_fetch(AW'(4093));
        finish_stream(elapsed);
        check_eq("oor_rate", elapsed, 6);

        // write while stalled: flush and refetch from the unconsumed head
        start_fetch(5);
        repeat (6) begin @(posedge clock); #1; end
        check_eq("coh_head", instr_addr, 5);
        cfg_write(6, 32'h0000_00AB);
        check_eq("coh_flush", instr_valid, 0);
        check_eq("coh_active", fetch_active, 1);
        @(posedge clock); #1;
        check_eq("coh_gap", instr_valid, 0);
        @(posedge clock); #1;
        check_eq("coh_resume", instr_valid, 1);
        check_eq("coh_addr", instr_addr, 5);
        expect_from(5, 4);
        pop_limit = pops + 4;
        instr_ready = 1'b1;
        finish_stream(elapsed);

        // write during full-rate streaming: no duplicates or gaps, new data seen
        expect_from(AW'(32), 12);
        pop_limit = pops + 12;
        instr_ready = 1'b1;
        start_fetch(AW'(32));
        repeat (4) begin @(posedge clock); #1; end
        cfg_write(AW'(42), 32'h00C0_FFEE);
        finish_stream(elapsed);

        // start and stop together while fetching: start wins
        start_fetch(AW'(40));
        repeat (3) begin @(posedge clock); #1; end
        fetch_pc = AW'(8); fetch_start = 1'b1; fetch_stop = 1'b1;
        @(posedge clock); #1;
        fetch_start = 1'b0; fetch_stop = 1'b0;
        check_eq("both_active", fetch_active, 1);
        expect_from(8, 3);
        pop_limit = pops + 3;
        instr_ready = 1'b1;
        finish_stream(elapsed);

        // reset mid-stream keeps memory
        start_fetch(0);
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("mrst_active", fetch_active, 0);
        check_eq("mrst_valid", instr_valid, 0);
        check_eq("mrst_data", instr_data, 0);
        check_eq("mrst_addr", instr_addr, 0);
        check_eq("mrst_err", instr_err, 0);
        reset = 1'b0;
        expect_from(0, 3);
        pop_limit = pops + 3;
        instr_ready = 1'b1;
        start_fetch(0);
        finish_stream(elapsed);

`ifdef PROG_MEM_PARITY_EN
        dut.mem[3][0] = ~dut.mem[3][0];
        exp_q.push_back(mk(2));
        drv_e      = mk(3);
        drv_e.data = drv_e.data ^ DW'(1);
        drv_e.err  = 1'b1;
        exp_q.push_back(drv_e);
        exp_q.push_back(mk(4));
        pop_limit = pops + 3;
        instr_ready = 1'b1;
        start_fetch(2);
        finish_stream(elapsed);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
